memory_access: RTL and testbench
================================

// Module: memory_access
// PURPOSE
//  MEM pipeline stage with EX/MEM -> MEM/WB register; directly feeds write_back.
//  Owns the data memory and performs little-endian byte/half/word loads and stores, sign- or zero-extending loads.
//  Flags misaligned accesses and passes ALU result, destination register and WB control to the next stage.
//  Provides a registered debug read port for the debug unit.
// PARAMETERS
//  N_BITS      32   datapath width
//  N_BITS_REG  5    register-index width
//  ADDR_BITS   8    word-address width; memory depth = 2**ADDR_BITS words
// PORTS
//  i_clk           in   1           clock, all state updates on posedge
//  i_reset         in   1           synchronous reset, ACTIVE-LOW (0 = reset)
//  i_valid         in   1           pipeline enable; 0 = stall/hold
//  i_memRead       in   1           instruction is a load
//  i_memWrite      in   1           instruction is a store
//  i_size          in   2           00 byte, 01 half, 10 word, 11 treated as word
//  i_unsigned      in   1           1 = zero-extend load, 0 = sign-extend
//  i_memToReg      in   1           WB mux select, passed through
//  i_regWrite      in   1           WB write enable, passed through
//  i_AluResult     in   N_BITS      effective byte address / ALU result
//  i_writeData     in   N_BITS      store data, right-aligned (rt value)
//  i_rd            in   N_BITS_REG  destination register
//  i_dbg_addr      in   ADDR_BITS   debug word address
//  o_datoLeido_MEM out  N_BITS      extended load data
//  o_AluResult     out  N_BITS      registered ALU result
//  o_rd            out  N_BITS_REG  registered destination register
//  o_memToReg      out  1           registered WB mux select
//  o_regWrite      out  1           registered WB write enable
//  o_misaligned    out  1           registered misaligned-access flag
//  o_dbg_data      out  N_BITS      registered memory word at i_dbg_addr
// BEHAVIOUR
//  - Reset (i_reset==0 at posedge): all outputs 0. Memory contents are NOT cleared. No store occurs in the reset cycle.
//  - Word index = i_AluResult[ADDR_BITS+1:2]; byte lane = i_AluResult[1:0]. Upper address bits are ignored (wrap-around).
//  - Misaligned: half with addr[0]==1, or word with addr[1:0]!=0, and (memRead|memWrite).
//    Result: no memory write, o_datoLeido_MEM=0, o_misaligned=1. regWrite is still passed unchanged.
//  - Store (valid & memWrite & !misaligned): at posedge, write only the addressed lanes.
//    byte: i_writeData[7:0] -> lane addr[1:0]; half: [15:0] -> lanes {addr[1],0}+1..+0; word: all 4.
//  - Load: latency 1. Memory word is read, lane-selected, then extended.
//    o_datoLeido_MEM is updated on the same posedge as the other MEM/WB outputs.
//    If memRead==0, o_datoLeido_MEM = 0.
//  - memRead & memWrite together: store is performed; load data reflects the OLD word (read-before-write).
//  - i_valid==0 (reset inactive): all MEM/WB outputs hold; no memory write.
//  - o_dbg_data: updated every posedge from mem[i_dbg_addr], independent of i_valid, 0 on reset.
//    A store and a debug read to the same word in one cycle returns the old word.
//  - Reset asserted mid-stall: reset wins and clears outputs.
//  - Pass-through fields: o_AluResult, o_rd, o_memToReg, o_regWrite latch inputs when valid.
// TESTING
//  1. Reset low 2 cycles -> all outputs 0. Release; store word 0xDEADBEEF @0x10, then load word @0x10 -> o_datoLeido_MEM=0xDEADBEEF one cycle later.
//  2. Store byte 0x80 @0x21, load signed byte @0x21 -> 0xFFFFFF80; load unsigned -> 0x00000080; other lanes of word 0x20 unchanged.
//  3. Store half 0x1234 @0x06 (lanes 2,3) -> load word @0x04 = 0x1234xxxx, xxxx = prior contents; half @0x03 -> o_misaligned=1, data 0, memory unchanged.
//  4. i_valid=0 for 3 cycles with memWrite=1 -> outputs frozen, memory unchanged; i_valid=1 resumes with next input.
//  5. Word address wrap: store @ (4<<ADDR_BITS)+8 -> o_dbg_data at i_dbg_addr=2 reads the stored word; load+store same cycle same word returns old value.
//  6. Assert reset during stalled load -> outputs 0 next cycle; memory keeps earlier stored data (verify via debug port).

Source files
------------

// File: rtl/memory_access.sv
// MEM pipeline stage: owns the data memory, performs little-endian byte/half/word
// loads and stores with sign or zero extension, flags misaligned accesses and
// registers everything into the MEM/WB boundary. A registered debug read port
// lets the debug unit inspect memory words without disturbing the pipeline.
module memory_access #(
  parameter int N_BITS     = 32,
  parameter int N_BITS_REG = 5,
  parameter int ADDR_BITS  = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_valid,
  input  logic                  i_memRead,
  input  logic                  i_memWrite,
  input  logic [1:0]            i_size,
  input  logic                  i_unsigned,
  input  logic                  i_memToReg,
  input  logic                  i_regWrite,
  input  logic [N_BITS-1:0]     i_AluResult,
  input  logic [N_BITS-1:0]     i_writeData,
  input  logic [N_BITS_REG-1:0] i_rd,
  input  logic [ADDR_BITS-1:0]  i_dbg_addr,
  output logic [N_BITS-1:0]     o_datoLeido_MEM,
  output logic [N_BITS-1:0]     o_AluResult,
  output logic [N_BITS_REG-1:0] o_rd,
  output logic                  o_memToReg,
  output logic                  o_regWrite,
  output logic                  o_misaligned,
  output logic [N_BITS-1:0]     o_dbg_data
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam int LANES = N_BITS / 8;

  // Access width encodings; 2'b11 behaves exactly like a word access.
  typedef enum logic [1:0] {
    SIZE_BYTE     = 2'b00,
    SIZE_HALF     = 2'b01,
    SIZE_WORD     = 2'b10,
    SIZE_WORD_ALT = 2'b11
  } access_size_t;

  // Data memory, word organised. Deliberately not reset so that contents
  // survive a pipeline reset and can be inspected afterwards.
  logic [N_BITS-1:0] mem [DEPTH];

  access_size_t         access_size;
  logic [ADDR_BITS-1:0] word_idx;
  logic [1:0]           lane;
  logic                 is_byte;
  logic                 is_half;
  logic                 is_word;
  logic                 misaligned_access;
  logic                 store_en;
  logic [LANES-1:0]     byte_en;
  logic [N_BITS-1:0]    write_word;
  logic [N_BITS-1:0]    old_word;
  logic [N_BITS-1:0]    lane_shifted;
  logic [N_BITS-1:0]    extended;
  logic [N_BITS-1:0]    load_value;

  // Address decode and misalignment detection. Upper address bits beyond the
  // memory depth are ignored, so addresses wrap around the memory.
  always_comb begin
    access_size       = access_size_t'(i_size);
    word_idx          = i_AluResult[ADDR_BITS+1:2];
    lane              = i_AluResult[1:0];
    is_byte           = (access_size == SIZE_BYTE);
    is_half           = (access_size == SIZE_HALF);
    is_word           = (access_size == SIZE_WORD) || (access_size == SIZE_WORD_ALT);
    misaligned_access = (i_memRead | i_memWrite) &
                        ((is_half & lane[0]) | (is_word & (lane != 2'b00)));
    store_en          = i_reset & i_valid & i_memWrite & ~misaligned_access;
  end

  // Byte-lane enables and lane-replicated store data for the addressed lanes.
  always_comb begin
    byte_en    = '0;
    write_word = i_writeData;
    if (is_byte) begin
      byte_en[lane] = 1'b1;
      write_word    = {LANES{i_writeData[7:0]}};
    end else if (is_half) begin
      byte_en[{lane[1], 1'b0}]        = 1'b1;
      byte_en[{lane[1], 1'b0} + 2'd1] = 1'b1;
      write_word                      = {(LANES / 2){i_writeData[15:0]}};
    end else begin
      byte_en    = '1;
      write_word = i_writeData;
    end
  end

  // Load path: read the old word, shift the addressed lane down, then extend.
  // Reading here (before the clock edge) gives read-before-write semantics.
  always_comb begin
    old_word     = mem[word_idx];
    lane_shifted = old_word >> {lane, 3'b000};
    extended     = old_word;
    if (is_byte) begin
      extended = {{(N_BITS - 8){~i_unsigned & lane_shifted[7]}}, lane_shifted[7:0]};
    end else if (is_half) begin
      extended = {{(N_BITS - 16){~i_unsigned & lane_shifted[15]}}, lane_shifted[15:0]};
    end
    load_value = (i_memRead && !misaligned_access) ? extended : '0;
  end

  // Memory write port: only the enabled byte lanes of the addressed word change.
  always_ff @(posedge i_clk) begin
    for (int b = 0; b < LANES; b++) begin
      if (store_en && byte_en[b]) begin
        mem[word_idx][8*b +: 8] <= write_word[8*b +: 8];
      end
    end
  end

  // MEM/WB pipeline register: cleared by reset, holds while the stage stalls.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      o_datoLeido_MEM <= '0;
      o_AluResult     <= '0;
      o_rd            <= '0;
      o_memToReg      <= 1'b0;
      o_regWrite      <= 1'b0;
      o_misaligned    <= 1'b0;
    end else if (i_valid) begin
      o_datoLeido_MEM <= load_value;
      o_AluResult     <= i_AluResult;
      o_rd            <= i_rd;
      o_memToReg      <= i_memToReg;
      o_regWrite      <= i_regWrite;
      o_misaligned    <= misaligned_access;
    end
  end

  // Debug read port: samples the current (pre-store) word every cycle.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      o_dbg_data <= '0;
    end else begin
      o_dbg_data <= mem[i_dbg_addr];
    end
  end

endmodule

// File: tb/tb_memory_access.sv
// Testbench for memory_access: directed scenarios followed by randomized
// traffic, every output compared each cycle against a byte-addressed model.
module tb_memory_access;

  localparam int N_BITS     = 32;
  localparam int N_BITS_REG = 5;
  localparam int ADDR_BITS  = 8;
  localparam int BYTES      = 4 * (1 << ADDR_BITS);

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic                  valid;
  logic                  mem_read;
  logic                  mem_write;
  logic [1:0]            size;
  logic                  is_unsigned;
  logic                  mem_to_reg;
  logic                  reg_write;
  logic [N_BITS-1:0]     alu_result;
  logic [N_BITS-1:0]     write_data;
  logic [N_BITS_REG-1:0] rd;
  logic [ADDR_BITS-1:0]  dbg_addr;
  logic [N_BITS-1:0]     dato_leido;
  logic [N_BITS-1:0]     alu_out;
  logic [N_BITS_REG-1:0] rd_out;
  logic                  mem_to_reg_out;
  logic                  reg_write_out;
  logic                  misaligned;
  logic [N_BITS-1:0]     dbg_data;

  // Reference model: flat byte memory plus the expected registered outputs.
  logic [7:0]            model_mem [BYTES];
  logic [N_BITS-1:0]     exp_load;
  logic [N_BITS-1:0]     exp_alu;
  logic [N_BITS_REG-1:0] exp_rd;
  logic                  exp_mtr;
  logic                  exp_rw;
  logic                  exp_mis;
  logic [N_BITS-1:0]     exp_dbg;

  int assertions = 0;
  int failures   = 0;

  memory_access #(
    .N_BITS(N_BITS), .N_BITS_REG(N_BITS_REG), .ADDR_BITS(ADDR_BITS)
  ) dut (
    .i_clk(clk), .i_reset(reset_n), .i_valid(valid),
    .i_memRead(mem_read), .i_memWrite(mem_write), .i_size(size),
    .i_unsigned(is_unsigned), .i_memToReg(mem_to_reg), .i_regWrite(reg_write),
    .i_AluResult(alu_result), .i_writeData(write_data), .i_rd(rd),
    .i_dbg_addr(dbg_addr), .o_datoLeido_MEM(dato_leido), .o_AluResult(alu_out),
    .o_rd(rd_out), .o_memToReg(mem_to_reg_out), .o_regWrite(reg_write_out),
    .o_misaligned(misaligned), .o_dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // Watchdog so the run can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertions++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] model_word(input int w);
    return {model_mem[4*w+3], model_mem[4*w+2], model_mem[4*w+1], model_mem[4*w]};
  endfunction

  // Advance the model by one clock using the current inputs, then clock the DUT
  // and compare every output.
  task automatic step();
    int          a;
    int          width;
    logic [31:0] value;
    if (!reset_n) begin
      exp_load = 0; exp_alu = 0; exp_rd = 0; exp_mtr = 0; exp_rw = 0;
      exp_mis = 0; exp_dbg = 0;
    end else begin
      exp_dbg = model_word(int'(dbg_addr));
      if (valid) begin
        a     = int'(alu_result & (BYTES - 1));
        width = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        exp_mis = (mem_read || mem_write) && (a % width != 0);
        value = 0;
        if (mem_read && !exp_mis) begin
          for (int k = 0; k < width; k++) value |= 32'(model_mem[a+k]) << (8*k);
          if (!is_unsigned && width < 4 && value[8*width-1])
            value |= 32'hFFFF_FFFF << (8*width);
        end
        exp_load = value;
        exp_alu  = alu_result;
        exp_rd   = rd;
        exp_mtr  = mem_to_reg;
        exp_rw   = reg_write;
        if (mem_write && !exp_mis)
          for (int k = 0; k < width; k++) model_mem[a+k] = write_data[8*k +: 8];
      end
    end
    @(posedge clk);
    #1;
    checkOutput("load_data",  dato_leido, exp_load);
    checkOutput("alu_result", alu_out, exp_alu);
    checkOutput("rd",         32'(rd_out), 32'(exp_rd));
    checkOutput("mem_to_reg", 32'(mem_to_reg_out), 32'(exp_mtr));
    checkOutput("reg_write",  32'(reg_write_out), 32'(exp_rw));
    checkOutput("misaligned", 32'(misaligned), 32'(exp_mis));
    checkOutput("dbg_data",   dbg_data, exp_dbg);
  endtask

  task automatic applyStimulus(input logic rst_n, input logic v, input logic mr,
                               input logic mw, input logic [1:0] sz, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wd,
                               input logic [7:0] dbg);
    reset_n     = rst_n;
    valid       = v;
    mem_read    = mr;
    mem_write   = mw;
    size        = sz;
    is_unsigned = uns;
    alu_result  = addr;
    write_data  = wd;
    dbg_addr    = dbg;
    rd          = N_BITS_REG'($urandom);
    mem_to_reg  = 1'($urandom);
    reg_write   = 1'($urandom);
    step();
  endtask

  initial begin
    logic [31:0] before_word;
    logic [31:0] addr;
    reset_n = 0; valid = 0; mem_read = 0; mem_write = 0; size = 0; is_unsigned = 0;
    mem_to_reg = 0; reg_write = 0; alu_result = 0; write_data = 0; rd = 0; dbg_addr = 0;

    // Reset for two cycles: all outputs zero.
    applyStimulus(0, 1, 1, 0, 2, 0, 32'h10, 0, 0);
    applyStimulus(0, 1, 1, 0, 2, 0, 32'h10, 0, 0);

    // Give every memory word a known value so the model is fully defined.
    for (int w = 0; w < (1 << ADDR_BITS); w++)
      applyStimulus(1, 1, 0, 1, 2, 0, 32'(4*w), $urandom, 8'($urandom));

    // Word store then load.
    applyStimulus(1, 1, 0, 1, 2, 0, 32'h10, 32'hDEADBEEF, 8'h04);
    applyStimulus(1, 1, 1, 0, 2, 0, 32'h10, 0, 8'h04);
    checkOutput("t1_word_load", dato_leido, 32'hDEADBEEF);

    // Byte store, signed and unsigned byte loads, neighbouring lanes intact.
    applyStimulus(1, 1, 0, 1, 0, 0, 32'h21, 32'h0000_0080, 0);
    applyStimulus(1, 1, 1, 0, 0, 0, 32'h21, 0, 0);
    checkOutput("t2_signed_byte", dato_leido, 32'hFFFF_FF80);
    applyStimulus(1, 1, 1, 0, 0, 1, 32'h21, 0, 0);
    checkOutput("t2_unsigned_byte", dato_leido, 32'h0000_0080);
    applyStimulus(1, 1, 1, 0, 2, 0, 32'h20, 0, 8'h08);

    // Half store into upper lanes, word readback, misaligned half store.
    applyStimulus(1, 1, 0, 1, 1, 0, 32'h06, 32'hABCD_1234, 0);
    applyStimulus(1, 1, 1, 0, 2, 0, 32'h04, 0, 0);
    checkOutput("t3_upper_half", {16'h0, dato_leido[31:16]}, 32'h1234);
    before_word = model_word(0);
    applyStimulus(1, 1, 1, 1, 1, 0, 32'h03, 32'h5555, 0);
    checkOutput("t3_misaligned_flag", 32'(misaligned), 1);
    checkOutput("t3_misaligned_data", dato_leido, 0);
    applyStimulus(1, 1, 0, 0, 2, 0, 32'h0, 0, 0);
    checkOutput("t3_mem_unchanged", dbg_data, before_word);

    // Stall with stores pending: outputs frozen, memory untouched.
    before_word = model_word(12);
    for (int i = 0; i < 3; i++)
      applyStimulus(1, 0, 0, 1, 2, 0, 32'h30, 32'h1111_2222, 8'd12);
    checkOutput("t4_stall_mem", dbg_data, before_word);
    applyStimulus(1, 1, 1, 0, 2, 1, 32'h30, 0, 8'd12);

    // Address wrap-around and read-before-write on the same word.
    applyStimulus(1, 1, 0, 1, 2, 0, (32'd4 << ADDR_BITS) + 32'd8, 32'hCAFE_F00D, 8'd2);
    applyStimulus(1, 1, 1, 1, 2, 0, 32'h08, 32'h0BAD_0BAD, 8'd2);
    checkOutput("t5_wrap_dbg", dbg_data, 32'hCAFE_F00D);
    checkOutput("t5_rbw_load", dato_leido, 32'hCAFE_F00D);
    applyStimulus(1, 1, 0, 0, 2, 0, 32'h0, 0, 8'd2);
    checkOutput("t5_after_store", dbg_data, 32'h0BAD_0BAD);

    // Reset while stalled on a load; memory keeps earlier data.
    applyStimulus(1, 0, 1, 0, 2, 0, 32'h10, 0, 8'd4);
    applyStimulus(0, 0, 1, 0, 2, 0, 32'h10, 0, 8'd4);
    checkOutput("t6_reset_alu", alu_out, 0);
    applyStimulus(1, 1, 0, 0, 2, 0, 32'h0, 0, 8'd4);
    checkOutput("t6_mem_kept", dbg_data, 32'hDEADBEEF);

    // Randomized traffic, partly forced to aligned addresses.
    for (int i = 0; i < 3000; i++) begin
      logic [1:0] sz;
      sz   = 2'($urandom);
      addr = $urandom;
      if ($urandom_range(0, 1) == 1)
        addr = (sz == 2'd0) ? addr : (sz == 2'd1) ? {addr[31:1], 1'b0} : {addr[31:2], 2'b00};
      applyStimulus($urandom_range(0, 49) != 0, $urandom_range(0, 9) != 0,
                    1'($urandom), 1'($urandom), sz, 1'($urandom), addr, $urandom,
                    8'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
